// File: rtl/trace_fabric_mgmt_mux.sv
// Two-input round-robin Avalon-ST mux for the trace fabric management return path.
// One-entry buffer per input, one-entry output stage; the source index is prepended to the channel.
module trace_fabric_mgmt_mux #(
  parameter int DATA_WIDTH    = 1,
  parameter int CHANNEL_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [CHANNEL_WIDTH-1:0] in0_channel,
  input  logic                     in0_valid,
  output logic                     in0_ready,
  input  logic [DATA_WIDTH-1:0]    in0_data,
  input  logic [CHANNEL_WIDTH-1:0] in1_channel,
  input  logic                     in1_valid,
  output logic                     in1_ready,
  input  logic [DATA_WIDTH-1:0]    in1_data,
  output logic [CHANNEL_WIDTH:0]   out_channel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data
);

  logic                     in_valid [2];
  logic [DATA_WIDTH-1:0]    in_data [2];
  logic [CHANNEL_WIDTH-1:0] in_channel [2];
  logic                     in_ready [2];

  assign in_valid[0]   = in0_valid;
  assign in_valid[1]   = in1_valid;
  assign in_data[0]    = in0_data;
  assign in_data[1]    = in1_data;
  assign in_channel[0] = in0_channel;
  assign in_channel[1] = in1_channel;
  assign in0_ready     = in_ready[0];
  assign in1_ready     = in_ready[1];

  logic                     buf_valid_reg [2];
  logic [DATA_WIDTH-1:0]    buf_data_reg [2];
  logic [CHANNEL_WIDTH-1:0] buf_channel_reg [2];

  logic                     out_valid_reg;
  logic [CHANNEL_WIDTH:0]   out_channel_reg;
  logic [DATA_WIDTH-1:0]    out_data_reg;
  logic                     last_grant_reg;

  logic       acc;
  logic       grant_idx;
  logic [1:0] grant;

  // grant is one-hot and already qualified by the output stage being able to accept
  always_comb begin
    acc       = out_ready || !out_valid_reg;
    grant_idx = 1'b0;
    if (buf_valid_reg[0] && buf_valid_reg[1]) begin
      grant_idx = !last_grant_reg;
    end else if (buf_valid_reg[1]) begin
      grant_idx = 1'b1;
    end
    grant = 2'b00;
    if (acc && (buf_valid_reg[0] || buf_valid_reg[1])) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_in_buf
      // a draining buffer can take the next beat in the same cycle
      assign in_ready[gi] = !buf_valid_reg[gi] || grant[gi];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          buf_valid_reg[gi]   <= 1'b0;
          buf_data_reg[gi]    <= '0;
          buf_channel_reg[gi] <= '0;
        end else if (in_valid[gi] && in_ready[gi]) begin
          buf_valid_reg[gi]   <= 1'b1;
          buf_data_reg[gi]    <= in_data[gi];
          buf_channel_reg[gi] <= in_channel[gi];
        end else if (grant[gi]) begin
          buf_valid_reg[gi]   <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_reg   <= 1'b0;
      out_channel_reg <= '0;
      out_data_reg    <= '0;
      last_grant_reg  <= 1'b1;
    end else if (grant != 2'b00) begin
      out_valid_reg   <= 1'b1;
      out_data_reg    <= buf_data_reg[grant_idx];
      out_channel_reg <= {grant_idx, buf_channel_reg[grant_idx]};
      last_grant_reg  <= grant_idx;
    end else if (out_ready) begin
      out_valid_reg   <= 1'b0;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_channel = out_channel_reg;
  assign out_data    = out_data_reg;

endmodule

// File: tb/tb_trace_fabric_mgmt_mux.sv
// Directed bench for trace_fabric_mgmt_mux: queue-based reference model compared every cycle,
// a per-source order scoreboard, and hand-computed literal expectations per scenario.
module tb_trace_fabric_mgmt_mux;
  localparam int DW = 1;
  localparam int CW = 1;

  typedef logic [CW+DW-1:0] beat_t;  // {channel, data}
  typedef logic [CW+DW:0]   obeat_t; // {source, channel, data}

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] in0_channel, in1_channel;
  logic          in0_valid, in1_valid;
  logic          in0_ready, in1_ready;
  logic [DW-1:0] in0_data, in1_data;
  logic [CW:0]   out_channel;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  trace_fabric_mgmt_mux #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in0_channel(in0_channel), .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_channel(in1_channel), .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .out_channel(out_channel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // source traffic still to be offered, accepted beats awaiting output, and the model
  beat_t  tx0[$], tx1[$];
  beat_t  sb0[$], sb1[$];
  beat_t  m_q0[$], m_q1[$];
  obeat_t m_out[$];
  bit     m_last = 1'b1;

  // which source the model sends to the output stage this cycle (-1: none)
  function automatic int pick();
    if (!(out_ready || m_out.size() == 0)) return -1;
    if (m_q0.size() != 0 && m_q1.size() != 0) return m_last ? 0 : 1;
    if (m_q0.size() != 0) return 0;
    if (m_q1.size() != 0) return 1;
    return -1;
  endfunction

  initial begin
    int    g;
    bit    r0, r1, hs0, hs1;
    beat_t b;
    obeat_t ob;
    hs0 = 1'b0; hs1 = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = '0; in1_data = '0; in0_channel = '0; in1_channel = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_q0.delete(); m_q1.delete(); m_out.delete(); m_last = 1'b1;
      end else begin
        g  = pick();
        r0 = (m_q0.size() == 0) || (g == 0);
        r1 = (m_q1.size() == 0) || (g == 1);
        if (g >= 0) begin
          b = (g == 0) ? m_q0.pop_front() : m_q1.pop_front();
          m_out.delete();
          m_out.push_back({g[0], b});
          m_last = g[0];
        end else if (out_ready) begin
          m_out.delete();
        end
        if (in0_valid && r0) m_q0.push_back({in0_channel, in0_data});
        if (in1_valid && r1) m_q1.push_back({in1_channel, in1_data});
      end
      #1;
      if (hs0) void'(tx0.pop_front());
      if (hs1) void'(tx1.pop_front());
      in0_valid = (tx0.size() != 0);
      {in0_channel, in0_data} = (tx0.size() != 0) ? tx0[0] : beat_t'(0);
      in1_valid = (tx1.size() != 0);
      {in1_channel, in1_data} = (tx1.size() != 0) ? tx1[0] : beat_t'(0);
      @(negedge clk);
      hs0 = reset_n && in0_valid && in0_ready;
      hs1 = reset_n && in1_valid && in1_ready;
      if (chk_en) begin
        g = pick();
        chk("in0_ready", 32'(in0_ready), 32'((m_q0.size() == 0) || (g == 0)));
        chk("in1_ready", 32'(in1_ready), 32'((m_q1.size() == 0) || (g == 1)));
        chk("out_valid", 32'(out_valid), 32'(m_out.size() != 0));
        if (m_out.size() != 0) chk("out_beat", 32'({out_channel, out_data}), 32'(m_out[0]));
        if (!reset_n) begin
          sb0.delete(); sb1.delete();
        end else begin
          if (hs0) sb0.push_back({in0_channel, in0_data});
          if (hs1) sb1.push_back({in1_channel, in1_data});
          if (out_valid && out_ready) begin
            ob = {out_channel, out_data};
            if (ob[CW+DW] == 1'b0) begin
              chk("sb0_has_beat", 32'(sb0.size() != 0), 1);
              if (sb0.size() != 0) chk("sb0_order", 32'(ob[CW+DW-1:0]), 32'(sb0.pop_front()));
            end else begin
              chk("sb1_has_beat", 32'(sb1.size() != 0), 1);
              if (sb1.size() != 0) chk("sb1_order", 32'(ob[CW+DW-1:0]), 32'(sb1.pop_front()));
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_out(input string name, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (out_valid) break;
      step(1);
    end
    chk(name, 32'(i < limit), 1);
  endtask

  initial begin
    obeat_t cap[$];
    obeat_t held;
    int first, last;
    reset_n   = 1'b0;
    out_ready = 1'b1;
    tx0.push_back({1'b0, 1'b1});
    tx1.push_back({1'b1, 1'b0});

    // reset with both sources valid, then source 0 goes first
    step(1);
    chk_en = 1'b1;
    step(2);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_channel", 32'(out_channel), 0);
    chk("rst_out_data", 32'(out_data), 0);
    reset_n = 1'b1;
    wait_out("first_out_timeout", 20);
    chk("first_src", 32'(out_channel[CW]), 0);
    chk("first_data", 32'(out_data), 1);
    step(6);

    // single source, back-to-back, two-clock latency
    tx0.push_back({1'b1, 1'b1}); tx0.push_back({1'b1, 1'b0}); tx0.push_back({1'b1, 1'b1});
    first = -1; last = -1; cap.delete();
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        cap.push_back({out_channel, out_data});
      end
    end
    chk("single_first_cycle", first, 3);
    chk("single_last_cycle", last, 5);
    chk("single_count", cap.size(), 3);
    if (cap.size() == 3) begin
      chk("single_beat0", 32'(cap[0]), 32'(3'b011));
      chk("single_beat1", 32'(cap[1]), 32'(3'b010));
      chk("single_beat2", 32'(cap[2]), 32'(3'b011));
    end

    // contention from a fresh reset: strict alternation starting with source 0
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx0.push_back({1'b0, 1'b0});
      tx1.push_back({1'b0, 1'b1});
    end
    first = -1; last = -1; cap.delete();
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        cap.push_back({out_channel, out_data});
      end
    end
    chk("rr_count", cap.size(), 12);
    chk("rr_span", last - first, 11);
    foreach (cap[k]) chk("rr_alternate", 32'(cap[k][CW+DW]), k % 2);

    // backpressure: three beats stored, payload held, then round-robin drain
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx0.push_back({1'b0, 1'b0});
      tx1.push_back({1'b1, 1'b1});
    end
    wait_out("bp_out_timeout", 10);
    held = {out_channel, out_data};
    chk("bp_held_src", 32'(held[CW+DW]), 0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_stable", 32'({out_channel, out_data}), 32'(held));
    end
    chk("bp_in0_ready", 32'(in0_ready), 0);
    chk("bp_in1_ready", 32'(in1_ready), 0);
    chk("bp_stored", sb0.size() + sb1.size(), 3);
    out_ready = 1'b1;
    step(1);
    chk("bp_drain1_src", 32'(out_channel[CW]), 1);
    step(1);
    chk("bp_drain2_src", 32'(out_channel[CW]), 0);
    step(20);

    // single streaming source keeps its ready high through drain-and-refill
    for (int i = 0; i < 6; i++) tx1.push_back(beat_t'(i));
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (in1_valid) chk("refill_in1_ready", 32'(in1_ready), 1);
    end
    step(5);

    // reset while three beats are stored
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx0.push_back({1'b1, 1'b0});
      tx1.push_back({1'b0, 1'b1});
    end
    step(8);
    chk("mid_stored", sb0.size() + sb1.size(), 3);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_in0_ready", 32'(in0_ready), 1);
    chk("mid_in1_ready", 32'(in1_ready), 1);
    out_ready = 1'b1;
    step(20);
    chk("end_sb0_empty", sb0.size(), 0);
    chk("end_sb1_empty", sb1.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", checks_passed, checks_total);
    $fatal(1, "timeout");
  end

endmodule
